fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4, sequential PC increment in bytes.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk is the single clock and rst_n is the reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pc_write  input  1  hazard-unit enable; 0 holds PC.
REQ-007 ifid_write  input  1  IF/ID register capture enable; 0 holds IF/ID.
REQ-008 ifid_flush  input  1  squashes IF/ID contents to a bubble.
REQ-009 branch_taken  input  1  redirect PC to branch_target.
REQ-010 branch_target  input  32  branch destination address.
REQ-011 jump  input  1  redirect PC to jump_target.
REQ-012 jump_target  input  32  jump destination address.
REQ-013 im_addr  output  32  instruction-memory address (current PC).
REQ-014 im_instr  input  32  instruction word returned combinationally by instruction memory.
REQ-015 ifid_instr  output  32  registered instruction for decode.
REQ-016 ifid_pc_plus4  output  32  registered PC+PC_STEP for decode.
REQ-017 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-018 stall_cnt, flush_cnt  output  32 each  performance counters, present only when FETCH_PERF_CNT_EN is defined.

Function
REQ-019 im_addr SHALL equal the PC register combinationally; no added latency.
REQ-020 The next PC SHALL follow this priority: branch_taken selects branch_target; otherwise jump selects jump_target; otherwise the value is PC+PC_STEP.
REQ-021 Bits [1:0] of either target SHALL be forced to 2'b00 before loading into the PC.
REQ-022 PC+PC_STEP SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
REQ-023 The PC SHALL update on the rising clk edge when pc_write=1, or when branch_taken or jump is asserted; a redirect overrides a pc_write=0 stall.
REQ-024 When pc_write=0 and there is no redirect, the PC SHALL hold.
REQ-025 ifid_flush=1 SHALL clear IF/ID on the next edge: ifid_instr=32'h0 (NOP), ifid_pc_plus4=0, ifid_valid=0. This has priority over ifid_write.
REQ-026 Otherwise, ifid_write=1 SHALL capture im_instr and PC+PC_STEP and set ifid_valid=1; ifid_write=0 SHALL hold all IF/ID fields.
REQ-027 Fetch-to-decode latency SHALL be exactly one cycle.
REQ-028 Simultaneous redirect and flush SHALL both take effect in the same edge.

Reset
REQ-029 On rst_n=0 the block SHALL immediately set PC=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, and both counters=0, independent of clk.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending update.
REQ-031 The first fetch after rst_n deasserts SHALL be from RESET_PC.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN:
- Defined: stall_cnt increments on each cycle with pc_write=0 and no redirect; flush_cnt increments on each cycle with ifid_flush=1; both saturate at 32'hFFFF_FFFF.
- Undefined: both ports and both counters are absent, and all other behaviour is identical.

Structure
REQ-033 Shared package fetch_pkg SHALL hold NOP_INSTR (32'h0), the default for RESET_PC, and the PC_STEP constant.
REQ-034 The PC register with next-PC priority mux SHALL be a sub-module named pc_reg; the IF/ID register and counters SHALL stay in fetch_stage.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset, then 3 cycles with pc_write=ifid_write=1 -> im_addr 0,4,8; ifid_pc_plus4 4,8 one cycle later; ifid_valid=1.
- pc_write=0 and ifid_write=0 for 2 cycles at PC=0x10 -> im_addr stays 0x10; IF/ID unchanged; stall_cnt=2 (macro defined).
- branch_taken=1, branch_target=0x103, jump=1 in the same cycle -> next PC=0x100 (branch wins, bits [1:0] cleared).
- ifid_flush=1 with ifid_write=1 -> ifid_instr=0, ifid_valid=0, flush_cnt+1.
- PC=0xFFFF_FFFC with pc_write=1 -> next PC=0x0.
- rst_n asserted asynchronously mid-cycle during a redirect -> PC=RESET_PC before the next edge; ifid_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg -- constants and helpers shared by the instruction-fetch stage.
//   NOP_INSTR        : instruction word used for a squashed IF/ID slot
//   RESET_PC_DEFAULT : default reset vector for the PC
//   PC_STEP_DEFAULT  : default sequential PC increment (bytes)
//   word_align()     : clears address bits [1:0] of a redirect target
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg -- program counter with next-PC priority selection.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   pc_write_i          : hazard enable; 0 holds PC unless redirected
//   branch_taken_i      : redirect to branch_target_i (highest priority)
//   branch_target_i     : branch destination
//   jump_i              : redirect to jump_target_i
//   jump_target_i       : jump destination
//   pc_o                : current PC
//   pc_plus_step_o      : PC + PC_STEP (wraps modulo 2^32)
// ---------------------------------------------------------------------------
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_step_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // 32-bit add: carry out is dropped so the sequential PC wraps to zero.
  assign pc_plus_step_o = pc_q + 32'(PC_STEP);
  assign pc_o           = pc_q;

  // A redirect loads even while the hazard unit is stalling the PC.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken_i) begin
      pc_d = word_align(branch_target_i);
    end else if (jump_i) begin
      pc_d = word_align(jump_target_i);
    end else if (pc_write_i) begin
      pc_d = pc_plus_step_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch: PC, instruction-memory address and the
// IF/ID pipeline register.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   pc_write                    : 0 stalls the PC (redirects still load)
//   ifid_write                  : 0 holds the IF/ID register
//   ifid_flush                  : squash IF/ID to a bubble (beats ifid_write)
//   branch_taken, branch_target : branch redirect (beats jump)
//   jump, jump_target           : jump redirect
//   im_addr                     : instruction-memory address (= PC)
//   im_instr                    : combinational instruction-memory data
//   ifid_instr, ifid_pc_plus4   : registered instruction and PC+PC_STEP
//   ifid_valid                  : IF/ID holds a real instruction
//   stall_cnt, flush_cnt        : saturating performance counters, only
//                                 present when FETCH_PERF_CNT_EN is defined
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        ifid_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc_plus_step;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_write_i      (pc_write),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .pc_o            (im_addr),
    .pc_plus_step_o  (pc_plus_step)
  );

  // IF/ID register
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_plus4_q;
  logic        ifid_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus4_q <= 32'h0;
      ifid_valid_q    <= 1'b0;
    end else if (ifid_flush) begin
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus4_q <= 32'h0;
      ifid_valid_q    <= 1'b0;
    end else if (ifid_write) begin
      ifid_instr_q    <= im_instr;
      ifid_pc_plus4_q <= pc_plus_step;
      ifid_valid_q    <= 1'b1;
    end
  end

  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        stall_evt;

  // A cycle counts as a stall only when the PC really holds.
  assign stall_evt = !pc_write && !branch_taken && !jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- directed and randomized checks of fetch_stage against a
// behavioural model of the fetch rules. Counter checks are compiled in when
// FETCH_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pc_write = 1'b0;
  logic        ifid_write = 1'b0;
  logic        ifid_flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign im_instr = mem_word(im_addr);

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .im_addr       (im_addr),
    .im_instr      (im_instr),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
  logic        m_valid;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_stall = 32'h0; m_flush = 32'h0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".im_addr"}, im_addr, m_pc);
    chk({tag, ".ifid_instr"}, ifid_instr, m_instr);
    chk({tag, ".ifid_pc4"}, ifid_pc_plus4, m_pc4);
    chk({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic cycle(input string tag, input logic pw, input logic iw, input logic fl,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
    logic [31:0] old_pc;
    pc_write = pw; ifid_write = iw; ifid_flush = fl;
    branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    @(posedge clk);
    old_pc = m_pc;
    if (fl) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (iw) begin
      m_instr = mem_word(old_pc); m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
    end
    if (br)      m_pc = bt & 32'hFFFF_FFFC;
    else if (jp) m_pc = jt & 32'hFFFF_FFFC;
    else if (pw) m_pc = old_pc + 32'd4;
    if (!pw && !br && !jp && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    if (fl && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
    #1;
    $display("cycle %-8s pw=%0b iw=%0b fl=%0b br=%0b jp=%0b -> im_addr=%h ifid_pc4=%h valid=%0b",
             tag, pw, iw, fl, br, jp, im_addr, ifid_pc_plus4, ifid_valid);
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from the reset vector
    chk("s1_addr0", im_addr, 32'h0);
    cycle("seq1", 1, 1, 0, 0, 32'h0, 0, 32'h0);
    chk("s1_addr4", im_addr, 32'h4);
    chk("s1_pc4_4", ifid_pc_plus4, 32'h4);
    cycle("seq2", 1, 1, 0, 0, 32'h0, 0, 32'h0);
    chk("s1_addr8", im_addr, 32'h8);
    chk("s1_pc4_8", ifid_pc_plus4, 32'h8);
    chk("s1_valid", {31'h0, ifid_valid}, 32'h1);
    cycle("seq3", 1, 1, 0, 0, 32'h0, 0, 32'h0);
    cycle("seq4", 1, 1, 0, 0, 32'h0, 0, 32'h0);

    // Stall at PC=0x10
    chk("s2_at10", im_addr, 32'h10);
    cycle("stall1", 0, 0, 0, 0, 32'h0, 0, 32'h0);
    cycle("stall2", 0, 0, 0, 0, 32'h0, 0, 32'h0);
    chk("s2_hold", im_addr, 32'h10);
    chk("s2_ifid", ifid_pc_plus4, 32'h10);
`ifdef FETCH_PERF_CNT_EN
    chk("s2_stall_cnt", stall_cnt, 32'd2);
`endif

    // Branch and jump together: branch wins, low bits cleared
    cycle("brjmp", 1, 1, 0, 1, 32'h103, 1, 32'h200);
    chk("s3_branch", im_addr, 32'h100);

    // Flush beats write
    cycle("flush", 1, 1, 1, 0, 32'h0, 0, 32'h0);
    chk("s4_instr", ifid_instr, 32'h0);
    chk("s4_valid", {31'h0, ifid_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("s4_flush_cnt", flush_cnt, 32'd1);
`endif

    // Wrap at the top of the address space
    cycle("jmptop", 0, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFE);
    chk("s5_top", im_addr, 32'hFFFF_FFFC);
    cycle("wrap", 1, 1, 0, 0, 32'h0, 0, 32'h0);
    chk("s5_wrap", im_addr, 32'h0);
    chk("s5_wrap_pc4", ifid_pc_plus4, 32'h0);

    // Asynchronous reset in the middle of a redirect
    pc_write = 1; ifid_write = 1; branch_taken = 1; branch_target = 32'h40;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6_async_pc", im_addr, 32'h0);
    chk("s6_async_valid", {31'h0, ifid_valid}, 32'h0);
    @(posedge clk);
    #1 check_all("s6_held");
    @(negedge clk);
    rst_n = 1'b1;
    branch_taken = 0; branch_target = 32'h0;
    chk("s6_first_fetch", im_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic pw, iw, fl, br, jp;
      logic [31:0] bt, jt;
      pw = ($urandom_range(0, 3) != 0);
      iw = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 9) == 0);
      br = ($urandom_range(0, 9) == 0);
      jp = ($urandom_range(0, 9) == 0);
      bt = $urandom();
      jt = $urandom();
      cycle("rand", pw, iw, fl, br, bt, jp, jt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
